data_memory_access_controller: RTL and testbench
================================================

// Module: data_memory_access_controller
// PURPOSE
//  Multi-cycle load/store sequencer between the core's memory stage and the
//  word-organised data memory. Converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw
//  requests into word reads/writes. Sub-word stores are done as
//  read-modify-write, so a byte or halfword never clobbers the rest of the word.
//  Checks alignment and range, and sign/zero-extends load data.
// PARAMETERS
//  ADDR_WORDS_LOG2  8   word-address width; memory depth = 2**8 = 256 words
// PORTS
//  clk          in   1   rising-edge clock; single clock domain
//  reset        in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   controller can accept; high only in IDLE
//  req_write    in   1   1=store, 0=load
//  req_size     in   2   00=byte, 01=half, 10=word, 11=illegal
//  req_unsigned in   1   loads only: 1=zero-extend, 0=sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid   out  1   one-cycle completion pulse; no backpressure
//  resp_rdata   out  32  extended load data; 0 for stores and errors
//  resp_error   out  1   valid with resp_valid: misaligned/out-of-range/illegal size
//  mem_addr     out  8   word index = req_addr[9:2]
//  mem_read     out  1   word read strobe
//  mem_write    out  1   word write strobe
//  mem_wdata    out  32  full word to write
//  mem_rdata    in   32  read word; valid in cycle after mem_read is high
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1. resp_valid, resp_error, mem_read and
//    mem_write are 0. resp_rdata, mem_addr and mem_wdata are 32'h0/8'h0.
//    Reset mid-operation abandons the access. No write is issued after the
//    reset cycle.
//  - Accept: in IDLE, req_valid&&req_ready registers addr/size/write/
//    unsigned/wdata at the clock edge (cycle T0). Inputs are ignored outside IDLE.
//  - Error check at accept. Error if any of:
//      size==11
//      half with addr[0]!=0
//      word with addr[1:0]!=0
//      addr[31:10]!=0
//    On error: state goes to RESP; resp_valid=1, resp_error=1 in T1; no mem strobe.
//  - States and transitions:
//      IDLE -> READ    (load)
//      IDLE -> WRITE   (sw)
//      IDLE -> RMW_RD  (sb/sh)
//      IDLE -> RESP    (error)
//      READ -> RESP
//      WRITE -> RESP
//      RMW_RD -> RMW_WR -> RESP
//      RESP -> IDLE
//  - READ (T1): mem_read=1. RESP (T2) samples mem_rdata -> load latency 2.
//  - WRITE (T1): mem_write=1, mem_wdata=wdata. RESP at T2.
//  - RMW_RD (T1): mem_read=1.
//    RMW_WR (T2): mem_write=1, mem_wdata = mem_rdata with the selected lane
//    replaced. RESP at T3.
//  - Lanes are little-endian:
//      byte lane = addr[1:0], bits [8*off+7 : 8*off]
//      half lane = addr[1],   bits [16*addr[1]+15 : 16*addr[1]]
//  - Load extension: the selected lane goes to the low bits. Upper bits are
//    lane MSB when req_unsigned=0, else 0. Word loads pass through unchanged.
//  - mem_read and mem_write are never high together. Each is high for exactly
//    one cycle per access.
//  - resp_valid lasts exactly one cycle (RESP). resp_rdata/resp_error hold
//    until the next RESP.
//  - req_ready=0 from T1 until the cycle after RESP. Back-to-back throughput:
//    one access per 3 (load/sw) or 4 (sb/sh) cycles.
// STRUCTURE
//  - Shared package (mem_ctrl_pkg), imported by this block and the core's decode:
//      size codes SZ_BYTE, SZ_HALF, SZ_WORD
//      state encoding ST_IDLE, ST_READ, ST_WRITE, ST_RMW_RD, ST_RMW_WR, ST_RESP
//  - One combinational sub-module, mem_lane_align:
//      store merge (old word, data, size, offset -> new word)
//      load extract/extend (word, size, offset, unsigned -> data)
//  - The FSM and request registers live in this module.
// TESTING
//  1. lw addr=0x10, mem[4]=0xDEADBEEF -> mem_read at T1 with mem_addr=4;
//     resp_valid at T2 with rdata=0xDEADBEEF, error=0.
//  2. lb signed addr=0x13, mem[4]=0x80FF7F01 -> rdata=0xFFFFFF80;
//     lbu same address -> 0x00000080.
//  3. sb addr=0x21, wdata=0xAB, mem[8]=0x11223344 -> read T1, write T2 with
//     wdata=0x1122AB44, resp T3.
//  4. sh addr=0x22, wdata=0xCAFE over 0x11223344 -> 0xCAFE3344.
//     lh addr=0x22 then returns 0xFFFFCAFE.
//  5. Misalignment and range:
//       lw addr=0x12            -> resp T1, error=1, no mem strobe
//       sh addr=0x401           -> error
//       size=11                 -> error
//       sw addr=0x400           -> error (out of range)
//  6. Assert reset during RMW_RD of an sb -> no mem_write issued; IDLE and
//     req_ready=1 next cycle; memory word unchanged.
//     Also: req_valid held high continuously -> accepted only in IDLE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access path: request size codes
// and the load/store sequencer state encoding.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering between a memory word and right-aligned
// core data: store merge for read-modify-write, and load extract/extend.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Replace only the addressed lane of the old word with the store data.
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{offset, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: merged[{offset[1], 4'b0000} +: 16]   = wdata[15:0];
      SZ_WORD: merged                               = wdata;
      default: merged                               = word;
    endcase
  end

  // Move the addressed lane to the low bits and sign- or zero-extend it.
  always_comb begin
    lane_b    = word[{offset, 3'b000} +: 8];
    lane_h    = word[{offset[1], 4'b0000} +: 16];
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/data_memory_access_controller.sv
// Multi-cycle load/store sequencer between the memory stage and a
// word-organised data memory with one-cycle read latency.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  ST_IDLE   | ready for a request
//  ST_READ   | word read issued for a load
//  ST_WRITE  | full-word store written
//  ST_RMW_RD | old word read for a byte/half store
//  ST_RMW_WR | merged word written back
//  ST_RESP   | one-cycle response (load data sampled here)
module data_memory_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [1:0]                 req_size,
  input  logic                       req_unsigned,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       resp_valid,
  output logic [31:0]                resp_rdata,
  output logic                       resp_error,
  output logic [ADDR_WORDS_LOG2-1:0] mem_addr,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata
);

  state_e                     state_q, state_d;
  logic                       accept, req_err;
  logic                       write_q, unsigned_q, err_q, err_hold;
  logic [1:0]                 size_q, offset_q;
  logic [ADDR_WORDS_LOG2-1:0] word_q;
  logic [31:0]                wdata_q, rdata_hold, resp_data_now;
  logic [31:0]                merged, load_data;

  assign accept = req_valid && req_ready;

  // Flag illegal size, misalignment and addresses beyond the memory depth.
  always_comb begin
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ((req_addr >> (ADDR_WORDS_LOG2 + 2)) != 32'd0) req_err = 1'b1;
  end

  // Capture the request when it is accepted; held for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      offset_q   <= 2'b00;
      word_q     <= '0;
      wdata_q    <= 32'h0;
    end else if (accept) begin
      write_q    <= req_write;
      unsigned_q <= req_unsigned;
      err_q      <= req_err;
      size_q     <= req_size;
      offset_q   <= req_addr[1:0];
      word_q     <= req_addr[ADDR_WORDS_LOG2+1:2];
      wdata_q    <= req_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                 state_d = ST_RESP;
          else if (!req_write)         state_d = ST_READ;
          else if (req_size == SZ_WORD) state_d = ST_WRITE;
          else                         state_d = ST_RMW_RD;
        end
      end
      ST_READ:   state_d = ST_RESP;
      ST_WRITE:  state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_RMW_WR;
      ST_RMW_WR: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  mem_lane_align u_align (
    .word        (mem_rdata),
    .wdata       (wdata_q),
    .size        (size_q),
    .offset      (offset_q),
    .is_unsigned (unsigned_q),
    .merged      (merged),
    .load_data   (load_data)
  );

  // Strobes and response are decoded from the current state.
  always_comb begin
    req_ready     = (state_q == ST_IDLE);
    mem_read      = (state_q == ST_READ) || (state_q == ST_RMW_RD);
    mem_write     = (state_q == ST_WRITE) || (state_q == ST_RMW_WR);
    mem_wdata     = 32'h0;
    if (state_q == ST_WRITE)  mem_wdata = wdata_q;
    if (state_q == ST_RMW_WR) mem_wdata = merged;
    resp_valid    = (state_q == ST_RESP);
    resp_data_now = (err_q || write_q) ? 32'h0 : load_data;
    resp_rdata    = resp_valid ? resp_data_now : rdata_hold;
    resp_error    = resp_valid ? err_q : err_hold;
  end

  assign mem_addr = word_q;

  // Keep the last response visible until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_hold <= 32'h0;
      err_hold   <= 1'b0;
    end else if (state_q == ST_RESP) begin
      rdata_hold <= resp_data_now;
      err_hold   <= err_q;
    end
  end

endmodule

// File: tb/tb_data_memory_access_controller.sv
// Scoreboard bench: the driver queues expected responses and memory
// accesses; a negedge monitor pops and compares whatever the DUT presents.
module tb_data_memory_access_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [7:0]  mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  data_memory_access_controller dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;
  typedef struct { logic wr; logic [7:0] addr; logic [31:0] wdata; } macc_t;

  resp_t       rq[$];
  macc_t       mq[$];
  logic [31:0] mem [256];
  int          total = 0, bad = 0;
  int          cyc = 0, acc_cyc = 0, n_acc = 0, n_resp = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Word memory with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr];
  end

  // Monitor: memory strobes, responses, latency and accept count.
  always @(negedge clk) begin
    if (mem_read && mem_write) check("rd_wr_overlap", 32'd1, 32'd0);
    if (mem_read || mem_write) begin
      if (mq.size() == 0) check("unexpected_mem_strobe", {31'd0, mem_write}, 32'hFFFF_FFFF);
      else begin
        macc_t m;
        m = mq.pop_front();
        check("mem_kind", {31'd0, mem_write}, {31'd0, m.wr});
        check("mem_addr", {24'd0, mem_addr}, {24'd0, m.addr});
        if (m.wr) check("mem_wdata", mem_wdata, m.wdata);
      end
    end
    if (resp_valid) begin
      if (rq.size() == 0) check("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
      else begin
        resp_t r;
        r = rq.pop_front();
        check("resp_rdata", resp_rdata, r.rdata);
        check("resp_error", {31'd0, resp_error}, {31'd0, r.err});
        check("resp_latency", cyc - acc_cyc, r.lat);
      end
      n_resp++;
    end
    if (req_valid && req_ready) begin
      acc_cyc = cyc;
      n_acc++;
    end
  end

  task automatic exp_mem(input logic wr, input logic [7:0] a, input logic [31:0] wd);
    macc_t m;
    m.wr = wr; m.addr = a; m.wdata = wd;
    mq.push_back(m);
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
  endtask

  // Issue one request (called #1 after a posedge) and wait for its response.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
    resp_t r;
    int    n0, g;
    r.rdata = exp_rd; r.err = exp_err; r.lat = lat;
    rq.push_back(r);
    n0 = n_resp;
    drive(wr, sz, uns, a, wd);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    g = 0;
    while (n_resp == n0 && g < 10) begin
      @(posedge clk);
      g++;
    end
    if (n_resp == n0) check("resp_timeout", 32'd0, 32'd1);
    #1;
  endtask

  initial begin
    int a0, g;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h11223344;
    reset = 1'b1; req_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // lw
    exp_mem(1'b0, 8'd4, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // req_valid held high: accepted only when IDLE (three loads in 9 cycles)
    a0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      resp_t r;
      r.rdata = 32'hDEADBEEF; r.err = 1'b0; r.lat = 2;
      rq.push_back(r);
      exp_mem(1'b0, 8'd4, 32'h0);
    end
    g = n_resp;
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    req_valid = 1'b1;
    for (int i = 0; i < 30 && n_resp < g + 3; i++) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("held_valid_accepts", n_acc - a0, 32'd3);

    // sw then sub-word loads with both extensions
    exp_mem(1'b1, 8'd4, 32'h80FF7F01);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 2);
    exp_mem(1'b0, 8'd4, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    exp_mem(1'b0, 8'd4, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
    exp_mem(1'b0, 8'd4, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000007F, 1'b0, 2);
    exp_mem(1'b0, 8'd4, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2);
    exp_mem(1'b0, 8'd4, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00007F01, 1'b0, 2);

    // sb read-modify-write
    exp_mem(1'b0, 8'd8, 32'h0);
    exp_mem(1'b1, 8'd8, 32'h1122AB44);
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAB, 32'h0, 1'b0, 3);

    // restore, then sh over the original word and read it back
    exp_mem(1'b1, 8'd8, 32'h11223344);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2);
    exp_mem(1'b0, 8'd8, 32'h0);
    exp_mem(1'b1, 8'd8, 32'hCAFE3344);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000CAFE, 32'h0, 1'b0, 3);
    exp_mem(1'b0, 8'd8, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFFCAFE, 1'b0, 2);
    exp_mem(1'b0, 8'd8, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFE3344, 1'b0, 2);
    check("resp_rdata_hold", resp_rdata, 32'hCAFE3344);

    // errors: response in T1, no memory strobe
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b01, 1'b0, 32'h401, 32'h1234, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h400, 32'h5555, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b00, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1);
    check("resp_error_hold", {31'd0, resp_error}, 32'd1);

    // reset during RMW_RD of an sb abandons the access
    exp_mem(1'b0, 8'd8, 32'h0);
    drive(1'b1, 2'b00, 1'b0, 32'h21, 32'h55);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mid_write", {31'd0, mem_write}, 32'd0);
    repeat (4) @(posedge clk);
    #1 check("rst_mid_mem8", mem[8], 32'hCAFE3344);
    check("rq_drained", rq.size(), 32'd0);
    check("mq_drained", mq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
